data_memory_ctrl: RTL

- Parametrised, byte-addressed data memory with a request/done handshake and a configurable wait-state count.
- Sits in the MEM stage behind the pipeline's memory-access logic.
- Successor to the fixed word-only data memory. Adds byte/halfword/word access, sign-extending loads, a configurable base address and depth, and misalignment/range error reporting.
- Storage is big-endian: the byte at the lowest address is the most significant byte of a word.

---
 rtl/data_memory_ctrl_if.sv | 27 ++
 rtl/data_memory_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl_if.sv
// Request/completion bus between the MEM-stage access logic (master) and the
// byte-addressed data memory controller (slave).
interface data_memory_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  load_signed;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output req, we, size, load_signed, address, write_data,
    input  busy, done, error, read_data
  );

  modport slave (
    input  req, we, size, load_signed, address, write_data,
    output busy, done, error, read_data
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressed data memory with byte/halfword/word access,
// sign-extending loads, programmable wait states and error reporting.
module data_memory_ctrl #(
  parameter int              ADDR_WIDTH  = 32,
  parameter int              DATA_WIDTH  = 32,
  parameter int              DEPTH_BYTES = 4096,
  parameter longint unsigned BASE_ADDR   = 1024,
  parameter int              WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_memory_ctrl_if.slave   bus,
  output logic [1:0]          state_dbg
);

  // Handshake: req is sampled only while idle (busy = 0); the accepted request
  // is latched, later input changes are ignored, and completion is a single
  // cycle with done = 1, error and read_data valid only during that cycle.

  localparam int                  IDXW      = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH_BYTES);
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  sgn_q;
  logic [ADDR_WIDTH-1:0] off_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [DATA_WIDTH-1:0] rd_q;

  logic [7:0] mem [DEPTH_BYTES];

  logic [1:0]            nb_m1;
  logic [ADDR_WIDTH:0]   last_x;
  logic                  err_c;
  logic [IDXW-1:0]       idx0, idx1, idx2, idx3;
  logic [7:0]            b0, b1, b2, b3;
  logic [DATA_WIDTH-1:0] ld_val;
  logic                  commit;
  logic                  mem_we;

  always_comb begin
    nb_m1 = 2'd0;
    case (size_q)
      2'd1:    nb_m1 = 2'd1;
      2'd2:    nb_m1 = 2'd3;
      default: nb_m1 = 2'd0;
    endcase
    // One extra bit so offsets near the top of the address space cannot wrap.
    last_x = {1'b0, off_q} + {{(ADDR_WIDTH - 1){1'b0}}, nb_m1};
    err_c  = (size_q == 2'd3)
           | ((size_q == 2'd1) && off_q[0])
           | ((size_q == 2'd2) && (off_q[1:0] != 2'b00))
           | (last_x >= DEPTH_X);

    idx0 = off_q[IDXW-1:0];
    idx1 = idx0 + IDXW'(1);
    idx2 = idx0 + IDXW'(2);
    idx3 = idx0 + IDXW'(3);
    b0   = mem[idx0];
    b1   = mem[idx1];
    b2   = mem[idx2];
    b3   = mem[idx3];

    ld_val = '0;
    case (size_q)
      2'd0:    ld_val = {{24{sgn_q & b0[7]}}, b0};
      2'd1:    ld_val = {{16{sgn_q & b0[7]}}, b0, b1};
      default: ld_val = {b0, b1, b2, b3};
    endcase

    commit = (state == S_WAIT) && (cnt == 4'd0);
    mem_we = commit && we_q && !err_c;
  end

  // Storage has no reset; an asynchronous reset forces IDLE, so mem_we drops.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (size_q)
        2'd0: mem[idx0] <= wd_q[7:0];
        2'd1: begin
          mem[idx0] <= wd_q[15:8];
          mem[idx1] <= wd_q[7:0];
        end
        default: begin
          mem[idx0] <= wd_q[31:24];
          mem[idx1] <= wd_q[23:16];
          mem[idx2] <= wd_q[15:8];
          mem[idx3] <= wd_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q   <= bus.we;
            size_q <= bus.size;
            sgn_q  <= bus.load_signed;
            off_q  <= bus.address - BASE;
            wd_q   <= bus.write_data;
            cnt    <= WAIT_INIT;
            busy_q <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            done_q  <= 1'b1;
            error_q <= err_c;
            rd_q    <= (!we_q && !err_c) ? ld_val : '0;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          rd_q    <= '0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          rd_q    <= '0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.read_data = rd_q;
  assign state_dbg     = state;

endmodule
